// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Latency: enables/flushes are combinational on state and hazard inputs; state updates each clk edge.
// Backpressure: dmem_busy freezes every stage; imem_busy, load-use and HLT hold the PC; a taken branch flushes.
// Ports: hazard inputs from ID, ID/EX and EX/MEM, plus memory busy flags;
//        capture enables (pc_we..memwb_we), synchronous flush requests (ifid/idex/exmem),
//        halted status and a saturating stall_cnt for performance debug.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic [3:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             mem_br_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain, drain_nxt;
  logic          load_use;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = idex_memread && (idex_rd != 4'd0) &&
                    ((idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      drain <= '0;
    end else begin
      state <= state_nxt;
      drain <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;

    case (state)
      INIT: begin
        // Also the values seen while rst is held, since rst forces INIT.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_nxt   = RUN;
      end

      RUN: begin
        if (dmem_busy) begin
          // Full freeze: EX/MEM holds, so a pending branch is seen again later.
        end else if (mem_br_taken) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
          {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
        end else if (load_use) begin
          // One bubble: hold PC and IF/ID, inject a NOP into ID/EX.
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00111;
          idex_flush = 1'b1;
        end else if (imem_busy) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b01111;
          ifid_flush = 1'b1;
        end else if (id_halt) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b01111;
          ifid_flush = 1'b1;
          state_nxt  = HALTING;
          drain_nxt  = DW'(DRAIN_CYC);
        end else begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
        end
      end

      HALTING: begin
        if (dmem_busy) begin
          // Frozen pipeline: drain counter holds.
        end else if (mem_br_taken) begin
          // HLT was fetched down a mispredicted path: squash and resume.
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
          {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
          state_nxt = RUN;
        end else begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b01111;
          ifid_flush = 1'b1;
          drain_nxt  = drain - DW'(1);
          if (drain <= DW'(1)) begin
            state_nxt = HALTED;
          end
        end
      end

      HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (((state == RUN) || (state == HALTING)) && !pc_we && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
